// File: rtl/wb_regfile_stage_if.sv
// Signal bundle between the EX/WB buffer plus decode stage and the writeback register file.
interface wb_regfile_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 32
);

   logic [DATA_W-1:0] iDMEM;
   logic [DATA_W-1:0] iALU;
   logic [DATA_W-1:0] iI;
   logic [ADDR_W-1:0] iRd;
   logic [6:0]        iWB;
   logic              iN;
   logic              iZ;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              oN;
   logic              oZ;
   logic [CNT_W-1:0]  retired;

   // The pipeline and the decode stage drive the writeback inputs and the read addresses.
   modport master (
      output iDMEM, iALU, iI, iRd, iWB, iN, iZ, rs_addr, rt_addr,
      input  rs_data, rt_data, oN, oZ, retired
   );

   // The writeback stage consumes them and returns read data, flags and the retire count.
   modport slave (
      input  iDMEM, iALU, iI, iRd, iWB, iN, iZ, rs_addr, rt_addr,
      output rs_data, rt_data, oN, oZ, retired
   );

endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the result, writes the register file, commits N/Z flags,
// serves two bypassed combinational read ports and counts retired instructions.
module wb_regfile_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   wb_regfile_stage_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic              valid;
   logic              regWrite;
   logic              memToReg;
   logic              immToReg;
   logic              flagWrite;
   logic              wrEn;
   logic              flagEn;
   logic [DATA_W-1:0] result;
   logic [1:0]        unusedReserved;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              nFlag_q;
   logic              nFlag_d;
   logic              zFlag_q;
   logic              zFlag_d;
   logic [CNT_W-1:0]  retired_q;
   logic [CNT_W-1:0]  retired_d;

   // Bits [5:4] of the control word carry no meaning for this stage.
   assign unusedReserved = bus.iWB[5:4];

   // Decode the control word; a bubble (Valid=0) masks every enable, and the load
   // path takes priority over the immediate path in the result mux.
   always_comb begin
      valid     = bus.iWB[6];
      regWrite  = bus.iWB[0];
      memToReg  = bus.iWB[1];
      immToReg  = bus.iWB[2];
      flagWrite = bus.iWB[3];
      wrEn      = valid & regWrite;
      flagEn    = valid & flagWrite;
      if (memToReg) begin
         result = bus.iDMEM;
      end else if (immToReg) begin
         result = bus.iI;
      end else begin
         result = bus.iALU;
      end
   end

   // Register array: every entry, including entry 0, is an ordinary writable register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wrEn) begin
         regs_q[bus.iRd] <= result;
      end
   end

   // Read ports forward the value being written this cycle so decode never sees stale data.
   always_comb begin
      bus.rs_data = regs_q[bus.rs_addr];
      bus.rt_data = regs_q[bus.rt_addr];
      if (wrEn && (bus.rs_addr == bus.iRd)) begin
         bus.rs_data = result;
      end
      if (wrEn && (bus.rt_addr == bus.iRd)) begin
         bus.rt_data = result;
      end
   end

   // Flags and retire counter next state; the counter wraps naturally at all-ones.
   always_comb begin
      nFlag_d   = nFlag_q;
      zFlag_d   = zFlag_q;
      retired_d = retired_q;
      if (flagEn) begin
         nFlag_d = bus.iN;
         zFlag_d = bus.iZ;
      end
      if (valid) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   // Commit flags and retire count; reset drops any update in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         nFlag_q   <= 1'b0;
         zFlag_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         nFlag_q   <= nFlag_d;
         zFlag_q   <= zFlag_d;
         retired_q <= retired_d;
      end
   end

   assign bus.oN      = nFlag_q;
   assign bus.oZ      = zFlag_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed scoreboard bench for wb_regfile_stage, plus a narrow-counter build for wrap.
module tb_wb_regfile_stage;

   logic clock = 1'b0;
   logic reset_n;

   int checks   = 0;
   int failures = 0;

   logic [31:0] sbQ [$];
   logic [31:0] regModel [64];
   logic        nModel;
   logic        zModel;
   logic [31:0] retModel;
   logic [3:0]  retW;

   wb_regfile_stage_if #(.DATA_W(32), .ADDR_W(6), .CNT_W(32)) bus ();
   wb_regfile_stage_if #(.DATA_W(32), .ADDR_W(6), .CNT_W(4))  busW ();

   wb_regfile_stage #(.DATA_W(32), .ADDR_W(6), .CNT_W(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   wb_regfile_stage #(.DATA_W(32), .ADDR_W(6), .CNT_W(4)) dutW (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (busW)
   );

   always #5 clock = ~clock;

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] modelResult();
      if (bus.iWB[1]) return bus.iDMEM;
      if (bus.iWB[2]) return bus.iI;
      return bus.iALU;
   endfunction

   function automatic logic [31:0] modelRead(input logic [5:0] a);
      if (bus.iWB[6] && bus.iWB[0] && (a == bus.iRd)) return modelResult();
      return regModel[a];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) regModel[i] = 32'h0;
      nModel   = 1'b0;
      zModel   = 1'b0;
      retModel = 32'h0;
      retW     = 4'h0;
   endtask

   task automatic pushExpect(input logic [31:0] v);
      sbQ.push_back(v);
   endtask

   task automatic applyStimulus(input logic [6:0] wb, input logic [5:0] rd,
                                input logic [31:0] dmem, input logic [31:0] alu,
                                input logic [31:0] imm, input logic n, input logic z,
                                input logic [5:0] ra, input logic [5:0] rb);
      bus.iWB     = wb;
      bus.iRd     = rd;
      bus.iDMEM   = dmem;
      bus.iALU    = alu;
      bus.iI      = imm;
      bus.iN      = n;
      bus.iZ      = z;
      bus.rs_addr = ra;
      bus.rt_addr = rb;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed);
      logic [31:0] expected;
      checks++;
      if (sbQ.size() == 0) begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=<scoreboard empty>", tag, observed);
         return;
      end
      expected = sbQ.pop_front();
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkReads(input string tagA, input string tagB);
      pushExpect(modelRead(bus.rs_addr));
      checkOutput(tagA, bus.rs_data);
      pushExpect(modelRead(bus.rt_addr));
      checkOutput(tagB, bus.rt_data);
   endtask

   task automatic checkState(input string tag);
      pushExpect({31'h0, nModel});
      checkOutput({tag, "_oN"}, {31'h0, bus.oN});
      pushExpect({31'h0, zModel});
      checkOutput({tag, "_oZ"}, {31'h0, bus.oZ});
      pushExpect(retModel);
      checkOutput({tag, "_retired"}, bus.retired);
   endtask

   // Advance one rising edge and update the reference model from the driven inputs.
   task automatic stepClock();
      logic        doWr;
      logic        doFlag;
      logic        doCnt;
      logic        doCntW;
      logic [5:0]  rd;
      logic [31:0] res;
      logic        n;
      logic        z;
      doWr   = bus.iWB[6] && bus.iWB[0];
      doFlag = bus.iWB[6] && bus.iWB[3];
      doCnt  = bus.iWB[6];
      doCntW = busW.iWB[6];
      rd     = bus.iRd;
      res    = modelResult();
      n      = bus.iN;
      z      = bus.iZ;
      @(posedge clock);
      if (reset_n) begin
         if (doWr) regModel[rd] = res;
         if (doFlag) begin
            nModel = n;
            zModel = z;
         end
         if (doCnt) retModel = retModel + 32'h1;
         if (doCntW) retW = retW + 4'h1;
      end
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      modelReset();
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0, 6'd1);
      busW.iWB = 7'h00; busW.iRd = 6'd0; busW.iDMEM = 32'h0; busW.iALU = 32'h0;
      busW.iI = 32'h0; busW.iN = 1'b0; busW.iZ = 1'b0; busW.rs_addr = 6'd0; busW.rt_addr = 6'd0;

      // Power-on reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkState("resetInit");
      checkReads("resetInitRs", "resetInitRt");
      reset_n = 1'b1;
      stepClock();
      checkState("afterRelease");

      // ALU write with same-cycle bypass
      applyStimulus(7'h41, 6'd5, 32'hDEAD, 32'h1234, 32'hBEEF, 1'b0, 1'b0, 6'd5, 6'd6);
      pushExpect(32'h1234);
      checkOutput("aluBypassRs", bus.rs_data);
      checkReads("aluBypassRs2", "aluOtherRt");
      stepClock();
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd5, 6'd5);
      pushExpect(32'h1234);
      checkOutput("aluStoredRs", bus.rs_data);
      checkState("afterAlu");

      // Result mux priority and ignored reserved bits
      applyStimulus(7'h47, 6'd7, 32'hAAAA, 32'h1111, 32'h5555, 1'b0, 1'b0, 6'd7, 6'd0);
      pushExpect(32'hAAAA);
      checkOutput("muxMemBypass", bus.rs_data);
      stepClock();
      applyStimulus(7'h45, 6'd8, 32'hAAAA, 32'h1111, 32'h5555, 1'b0, 1'b0, 6'd7, 6'd8);
      pushExpect(32'h5555);
      checkOutput("muxImmBypass", bus.rt_data);
      stepClock();
      applyStimulus(7'h71, 6'd10, 32'hAAAA, 32'h7777, 32'h5555, 1'b0, 1'b0, 6'd7, 6'd8);
      stepClock();
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd7, 6'd8);
      pushExpect(32'hAAAA);
      checkOutput("muxMemStored", bus.rs_data);
      pushExpect(32'h5555);
      checkOutput("muxImmStored", bus.rt_data);
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd10, 6'd9);
      pushExpect(32'h7777);
      checkOutput("reservedIgnored", bus.rs_data);
      checkState("afterMux");

      // Bubble with every other control bit set
      applyStimulus(7'h0F, 6'd9, 32'h9999, 32'h9999, 32'h9999, 1'b1, 1'b1, 6'd9, 6'd9);
      pushExpect(32'h0);
      checkOutput("bubbleNoBypass", bus.rs_data);
      stepClock();
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd9, 6'd5);
      checkReads("bubbleReg9", "bubbleReg5");
      checkState("afterBubble");

      // Flag-only commit, then invalid flag write, then flag plus write to entry 0
      applyStimulus(7'h48, 6'd5, 32'h0, 32'hFFFF, 32'h0, 1'b1, 1'b0, 6'd5, 6'd0);
      pushExpect(32'h1234);
      checkOutput("flagNoBypass", bus.rs_data);
      stepClock();
      checkState("afterFlag");
      applyStimulus(7'h08, 6'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd5, 6'd0);
      stepClock();
      checkState("invalidFlag");
      applyStimulus(7'h49, 6'd0, 32'h0, 32'hCAFE, 32'h0, 1'b0, 1'b1, 6'd0, 6'd0);
      pushExpect(32'hCAFE);
      checkOutput("dualBypassRs", bus.rs_data);
      pushExpect(32'hCAFE);
      checkOutput("dualBypassRt", bus.rt_data);
      stepClock();
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0, 6'd5);
      checkReads("reg0Stored", "reg5Kept");
      checkState("afterFlagWrite");

      // Asynchronous reset mid-run with a write in flight
      applyStimulus(7'h49, 6'd12, 32'h0, 32'hABCD, 32'h0, 1'b1, 1'b1, 6'd5, 6'd0);
      @(negedge clock);
      reset_n = 1'b0;
      modelReset();
      #1;
      checkReads("midResetRs", "midResetRt");
      checkState("midReset");
      stepClock();
      for (int i = 0; i < 64; i++) begin
         applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'(i), 6'(63 - i));
         checkReads("inResetRs", "inResetRt");
      end
      checkState("inReset");
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(7'h41, 6'd12, 32'h0, 32'h1357, 32'h0, 1'b0, 1'b0, 6'd12, 6'd5);
      stepClock();
      applyStimulus(7'h00, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd12, 6'd5);
      pushExpect(32'h1357);
      checkOutput("postResetWrite", bus.rs_data);
      checkReads("postResetRs", "postResetRt");
      checkState("postReset");

      // Counter wrap on the 4-bit build
      busW.iWB = 7'h40;
      for (int i = 0; i < 15; i++) stepClock();
      pushExpect({28'h0, retW});
      checkOutput("wrapModelAllOnes", 32'(busW.retired));
      pushExpect(32'hF);
      checkOutput("wrapAllOnes", 32'(busW.retired));
      stepClock();
      pushExpect(32'h0);
      checkOutput("wrapToZero", 32'(busW.retired));
      stepClock();
      busW.iWB = 7'h00;
      pushExpect(32'h1);
      checkOutput("wrapContinues", 32'(busW.retired));
      checkState("wrapMainIdle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
